rc5_key_sequencer: RTL
======================

// Module: rc5_key_sequencer
// PURPOSE
//  Controller between the rc5 frame decoder and its consumers. Turns raw decoded frames
//  (command + toggle bit) into key events: PRESS, REPEAT, RELEASE.
//  Uses toggle tracking, hold timeout and auto-repeat delay.
//  Events are buffered in a small FIFO with a valid/ready pop handshake, so slow consumers
//  (volume counter, menu logic) need no timing of their own.
// PARAMETERS
//  RELEASE_TIMEOUT  1500  cycles without a matching frame before a held key is released (>=2)
//  REPEAT_DELAY     3     frame index (press frame = 0) from which each matching frame emits REPEAT (>=1)
//  FIFO_DEPTH       4     event FIFO entries (power of 2, >=2)
// PORTS
//  i_clk        in   1  clock; sole clock domain
//  i_rst        in   1  synchronous, active-high reset
//  i_valid      in   1  one-cycle strobe: decoded frame available
//  i_command    in   6  decoded command, sampled when i_valid=1
//  i_control    in   1  toggle bit, sampled when i_valid=1
//  i_enable     in   1  0 = ignore frames; a held key is released
//  o_evt_valid  out  1  FIFO not empty (head event presented)
//  i_evt_ready  in   1  consumer pops head when o_evt_valid & i_evt_ready
//  o_evt_kind   out  2  head event kind: 0 PRESS, 1 REPEAT, 2 RELEASE
//  o_evt_cmd    out  6  head event command
//  o_held       out  1  1 while FSM in HELD or PEND
//  o_held_cmd   out  6  latched command of held key (0 when idle)
//  o_overflow   out  1  sticky: an event was dropped on a full FIFO
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty. All outputs 0. Timer, frame index and latched cmd/toggle are 0.
//  FSM states: IDLE, HELD, PEND. Each state pushes at most one event per cycle.
//  IDLE: i_valid & i_enable -> push PRESS(cmd); latch cmd/toggle; idx=0; timer=0 -> HELD.
//  HELD, i_valid with same cmd and same toggle:
//   - timer=0; idx=min(idx+1, REPEAT_DELAY).
//   - push REPEAT(cmd) when the new idx >= REPEAT_DELAY.
//  HELD, i_valid with different cmd or toggle:
//   - push RELEASE(old cmd); latch new cmd/toggle -> PEND.
//  PEND: push PRESS(latched cmd); idx=0; timer=0 -> HELD (one cycle). i_valid in PEND is ignored.
//  HELD timeout: timer increments each cycle without i_valid.
//   - At timer == RELEASE_TIMEOUT-1: push RELEASE(cmd) -> IDLE.
//   - Timeout wins over nothing; an i_valid in that same cycle takes priority (a frame restarts the hold).
//  i_enable=0: frames ignored in every state. In HELD or PEND: push RELEASE(cmd) -> IDLE next cycle.
//  Latency: frame strobe at cycle N -> PRESS visible on o_evt_valid at N+1 when FIFO empty.
//   - Toggle-change case: RELEASE at N+1, PRESS enqueued at N+2.
//  First frame after reset is always PRESS, whatever the toggle value.
//  Timer width $clog2(RELEASE_TIMEOUT+1); it never wraps (held at compare point).
//  FIFO: first-word-fall-through; o_evt_kind/o_evt_cmd valid only while o_evt_valid=1, else 0.
//   - Push when full and no pop: event dropped, o_overflow<=1 (cleared only by reset).
//   - Push when full with a pop in the same cycle: accepted.
//   - Pop when empty: no-op.
//   - Order strictly preserved; pointers wrap modulo FIFO_DEPTH.
//  Reset mid-operation discards state and queued events; no RELEASE is emitted.
// STRUCTURE
//  Shared package rc5_pkg:
//   - event kind constants EVT_PRESS / EVT_REPEAT / EVT_RELEASE (2 bits)
//   - RC5_CMD_W=6
//   - RC5_INCR_VOLUME=16, RC5_DECR_VOLUME=17
//   - FSM state encoding
//  Sub-module rc5_evt_fifo:
//   - generic sync FIFO, width 8 {kind,cmd}, depth FIFO_DEPTH
//   - outputs: full, empty, drop flag
//  Top of this block: FSM + timer + idx + latch, single push port into the FIFO.
// TESTING
//  Test params: RELEASE_TIMEOUT=50, REPEAT_DELAY=3, FIFO_DEPTH=4; ready=1 unless stated.
//  1 Reset; one frame cmd16 tog0 at cycle N -> PRESS(16) at N+1; RELEASE(16) at N+51; o_held 1->0.
//  2 Five frames cmd16 tog0 spaced 20 cycles -> PRESS, REPEAT, REPEAT (frames 3,4), then RELEASE(16) 50 cycles after last.
//  3 Frame cmd17 tog0, 20 cycles later cmd17 tog1 -> PRESS17, RELEASE17, PRESS17 (last two consecutive cycles).
//  4 ready=0, six events generated -> 4 queued, o_overflow=1; ready=1 drains first four in order, flag stays 1.
//  5 i_rst while HELD with 2 queued -> next cycle o_evt_valid=0, o_held=0, o_overflow=0; later frame -> PRESS.
//  6 i_enable=0 while HELD -> RELEASE next cycle; frames during enable=0 produce nothing; re-enable + frame -> PRESS.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared definitions for the rc5 key sequencer: event kinds, command width,
// well-known command codes and the sequencer FSM encoding.
package rc5_pkg;

    localparam int RC5_CMD_W = 6;
    localparam int RC5_EVT_W = 2 + RC5_CMD_W;

    localparam logic [RC5_CMD_W-1:0] RC5_INCR_VOLUME = 6'd16;
    localparam logic [RC5_CMD_W-1:0] RC5_DECR_VOLUME = 6'd17;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_REPEAT  = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_PEND = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rc5_key_sequencer_if.sv
// Key-event pop handshake between the sequencer (master) and a consumer (slave).
interface rc5_key_sequencer_if;
    import rc5_pkg::*;

    logic                 o_evt_valid;
    logic                 i_evt_ready;
    logic [1:0]           o_evt_kind;
    logic [RC5_CMD_W-1:0] o_evt_cmd;

    modport master (output o_evt_valid, o_evt_kind, o_evt_cmd, input i_evt_ready);
    modport slave  (input o_evt_valid, o_evt_kind, o_evt_cmd, output i_evt_ready);

endinterface

// File: rtl/rc5_evt_fifo.sv
// Generic first-word-fall-through sync FIFO with a sticky drop flag.
// Data reads as zero while empty; a push on full is accepted only with a same-cycle pop.
module rc5_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             drop_q, drop_d;
    logic             push_ok, pop_ok;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_empty  = (count_q == '0);
        o_full   = (count_q == FULL_CNT);
        pop_ok   = i_pop && !o_empty;
        push_ok  = i_push && (!o_full || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        drop_d   = drop_q || (i_push && !push_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

    assign o_data = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_drop = drop_q;

endmodule

// File: rtl/rc5_key_sequencer.sv
// Turns decoded rc5 frames into PRESS / REPEAT / RELEASE key events using toggle
// tracking, a hold timeout and an auto-repeat delay; events queue in a small FIFO.
module rc5_key_sequencer
    import rc5_pkg::*;
#(
    parameter int RELEASE_TIMEOUT = 1500,
    parameter int REPEAT_DELAY    = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [RC5_CMD_W-1:0] i_command,
    input  logic                 i_control,
    input  logic                 i_enable,
    output logic                 o_held,
    output logic [RC5_CMD_W-1:0] o_held_cmd,
    output logic                 o_overflow,
    rc5_key_sequencer_if.master  evt
);
    localparam int TIMER_W = $clog2(RELEASE_TIMEOUT + 1);
    localparam int IDX_W   = $clog2(REPEAT_DELAY + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(RELEASE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX      = IDX_W'(REPEAT_DELAY);

    seq_state_e           state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RC5_CMD_W-1:0] cmd_q, cmd_d;
    logic                 tog_q, tog_d;

    logic                 push;
    evt_kind_e            push_kind;
    logic [RC5_CMD_W-1:0] push_cmd;
    logic [RC5_EVT_W-1:0] head_data;
    logic                 fifo_empty, fifo_full;
    logic                 same_key;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        tog_d     = tog_q;
        push      = 1'b0;
        push_kind = EVT_PRESS;
        push_cmd  = cmd_q;
        same_key  = (i_command == cmd_q) && (i_control == tog_q);

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable && i_valid) begin
                    push     = 1'b1;
                    push_cmd = i_command;
                    cmd_d    = i_command;
                    tog_d    = i_control;
                    idx_d    = '0;
                    timer_d  = '0;
                    state_d  = ST_HELD;
                end
            end
            ST_HELD: begin
                // A frame outranks the timeout; a disable outranks both.
                if (!i_enable) begin
                    push      = 1'b1;
                    push_kind = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end else if (i_valid && same_key) begin
                    timer_d   = '0;
                    idx_d     = (idx_q >= IDX_MAX) ? IDX_MAX : idx_q + IDX_W'(1);
                    push      = (idx_d == IDX_MAX);
                    push_kind = EVT_REPEAT;
                end else if (i_valid) begin
                    push      = 1'b1;
                    push_kind = EVT_RELEASE;
                    cmd_d     = i_command;
                    tog_d     = i_control;
                    state_d   = ST_PEND;
                end else if (timer_q == TIMEOUT_LAST) begin
                    push      = 1'b1;
                    push_kind = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_PEND: begin
                push    = 1'b1;
                idx_d   = '0;
                timer_d = '0;
                if (!i_enable) begin
                    push_kind = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end else begin
                    push_kind = EVT_PRESS;
                    state_d   = ST_HELD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            cmd_d   = '0;
            tog_d   = 1'b0;
            idx_d   = '0;
            timer_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            tog_q   <= tog_d;
        end
    end

    rc5_evt_fifo #(
        .WIDTH (RC5_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data ({push_kind, push_cmd}),
        .i_pop       (evt.i_evt_ready),
        .o_data      (head_data),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_drop      (o_overflow)
    );

    assign evt.o_evt_valid = !fifo_empty;
    assign evt.o_evt_kind  = head_data[RC5_EVT_W-1 -: 2];
    assign evt.o_evt_cmd   = head_data[RC5_CMD_W-1:0];
    assign o_held          = (state_q == ST_HELD) || (state_q == ST_PEND);
    assign o_held_cmd      = cmd_q;

endmodule
